or_bist_checker: RTL and testbench

//  On-board self-test for the basic_or gate on the Mojo board. Drives every {a,b} combination

---
 rtl/or_bist_checker_pkg.sv | 19 +
 rtl/or_bist_checker_if.sv | 29 ++
 rtl/basic_or.sv | 10 +
 rtl/or_bist_vecgen.sv | 29 ++
 rtl/or_bist_checker.sv | 140 ++++++++++++++
 tb/tb_or_bist_checker.sv | 187 ++++++++++++++++++
 6 files changed

// File: rtl/or_bist_checker_pkg.sv
// Shared types and constants for the basic_or built-in self-test checker.
package or_bist_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned        ERR_W   = 8;
  localparam logic [ERR_W-1:0]   ERR_MAX = '1;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/or_bist_checker_if.sv
// Host-side control/status and DUT-side stimulus/response of the OR-gate self-test.
interface or_bist_checker_if #(
  parameter int unsigned WIDTH = 4
);
  import or_bist_checker_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic [WIDTH-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic [WIDTH-1:0] fail_out;

  modport master (
    input  start, dut_out,
    output dut_a, dut_b, busy, done, pass, err_count, fail_a, fail_b, fail_out
  );

  modport slave (
    output start, dut_out,
    input  dut_a, dut_b, busy, done, pass, err_count, fail_a, fail_b, fail_out
  );

endinterface

// File: rtl/basic_or.sv
// Bitwise OR gate; the unit exercised by or_bist_checker.
module basic_or #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
);
  assign out = a | b;
endmodule

// File: rtl/or_bist_vecgen.sv
// Vector index counter for the OR self-test; splits the index into operands a (high) and b (low).
module or_bist_vecgen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             last_o
);
  logic [2*WIDTH-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i)      idx_d = '0;
    else if (inc_i) idx_d = idx_q + (2*WIDTH)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign a_o    = idx_q[2*WIDTH-1:WIDTH];
  assign b_o    = idx_q[WIDTH-1:0];
  assign last_o = &idx_q;
endmodule

// File: rtl/or_bist_checker.sv
// Sweeps every {a,b} pair through an external OR gate, counting mismatches and capturing the first one.
module or_bist_checker #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst,
  or_bist_checker_if.master   bus
);
  import or_bist_checker_pkg::*;

  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [WIDTH-1:0] dut_a_q, dut_a_d, dut_b_q, dut_b_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d, fail_out_q, fail_out_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic             vec_inc, vec_clr, vec_last;
  logic [WIDTH-1:0] vec_a, vec_b;
  logic             mismatch, launch;

  or_bist_vecgen #(.WIDTH(WIDTH)) u_vecgen (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (vec_inc),
    .clr_i  (vec_clr),
    .a_o    (vec_a),
    .b_o    (vec_b),
    .last_o (vec_last)
  );

  assign mismatch = (bus.dut_out != (dut_a_q | dut_b_q));
  // In DONE, start is honoured only once done is visible, so the final-CHECK start is not queued.
  assign launch   = bus.start && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && done_q));

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    dut_a_d    = dut_a_q;
    dut_b_d    = dut_b_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_out_d = fail_out_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    vec_inc    = 1'b0;
    vec_clr    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_q == '0);
        end
        if (launch) begin
          err_d      = '0;
          fail_a_d   = '0;
          fail_b_d   = '0;
          fail_out_d = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
          vec_clr    = 1'b1;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        dut_a_d  = vec_a;
        dut_b_d  = vec_b;
        settle_d = '0;
        state_d  = (SETTLE > 0) ? ST_WAIT : ST_CHECK;
      end
      ST_WAIT: begin
        if (settle_q == SETTLE_LAST) state_d  = ST_CHECK;
        else                         settle_d = settle_q + 4'd1;
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_d = sat_inc(err_q);
          if (err_q == '0) begin
            fail_a_d   = dut_a_q;
            fail_b_d   = dut_b_q;
            fail_out_d = bus.dut_out;
          end
        end
        if (vec_last) begin
          state_d = ST_DONE;
        end else begin
          vec_inc = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      settle_q   <= '0;
      dut_a_q    <= '0;
      dut_b_q    <= '0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_out_q <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      dut_a_q    <= dut_a_d;
      dut_b_q    <= dut_b_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_out_q <= fail_out_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign bus.dut_a     = dut_a_q;
  assign bus.dut_b     = dut_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_a    = fail_a_q;
  assign bus.fail_b    = fail_b_q;
  assign bus.fail_out  = fail_out_q;
endmodule

// File: tb/tb_or_bist_checker.sv
// Directed bench for or_bist_checker: good and faulty OR gates, restart/reset corners, small config.
module tb_or_bist_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  int         total = 0;
  int         bad   = 0;

  always #10 clk = ~clk;

  or_bist_checker_if #(.WIDTH(4)) bus_a ();
  or_bist_checker_if #(.WIDTH(2)) bus_b ();

  logic [3:0] or_a;
  logic [1:0] or_b;

  basic_or #(.WIDTH(4)) u_or_a (.a(bus_a.dut_a), .b(bus_a.dut_b), .out(or_a));
  basic_or #(.WIDTH(2)) u_or_b (.a(bus_b.dut_a), .b(bus_b.dut_b), .out(or_b));

  // Fault injection on the 4-bit gate's response.
  always_comb begin
    case (mode)
      3'd1:    bus_a.dut_out = or_a & 4'b1110;
      3'd2:    bus_a.dut_out = 4'b0000;
      3'd3:    bus_a.dut_out = or_a | 4'b1000;
      3'd4:    bus_a.dut_out = bus_a.dut_a & bus_a.dut_b;
      3'd5:    bus_a.dut_out = ~or_a;
      default: bus_a.dut_out = or_a;
    endcase
  end
  assign bus_b.dut_out = or_b;

  or_bist_checker #(.WIDTH(4), .SETTLE(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  or_bist_checker #(.WIDTH(2), .SETTLE(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    int mode;
    int err;
    int fa;
    int fb;
    int fo;
    int ps;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the edge that sampled start.
  task automatic pulse_start();
    @(posedge clk); #1 bus_a.start = 1'b1;
    @(posedge clk); #1 bus_a.start = 1'b0;
    chk("entry_busy", 32'(bus_a.busy), 1);
    chk("entry_done", 32'(bus_a.done), 0);
    chk("entry_err",  32'(bus_a.err_count), 0);
  endtask

  task automatic wait_done(input int restart_at, output int n);
    bit fin;
    fin = 1'b0;
    n   = 0;
    while (!fin) begin
      @(posedge clk); n++;
      #1 bus_a.start = 1'b0;
      if (bus_a.done) fin = 1'b1;
      else if (n >= 3000) begin
        total++; bad++;
        $display("FAIL done_timeout: got no done after %0d cycles, expected 1025", n);
        fin = 1'b1;
      end else if (n == restart_at) bus_a.start = 1'b1;
    end
  endtask

  task automatic check_result(input string tag, input int n, input vec_t v);
    chk({tag, "_cycles"}, 32'(n), 1025);
    chk({tag, "_busy"},   32'(bus_a.busy), 0);
    chk({tag, "_pass"},   32'(bus_a.pass), v.ps);
    chk({tag, "_err"},    32'(bus_a.err_count), v.err);
    chk({tag, "_fail_a"}, 32'(bus_a.fail_a), v.fa);
    chk({tag, "_fail_b"}, 32'(bus_a.fail_b), v.fb);
    chk({tag, "_fail_o"}, 32'(bus_a.fail_out), v.fo);
  endtask

  initial begin
    int   n;
    vec_t v;

    tbl[0] = '{0,   0, 0, 0,  0, 1};  // good gate
    tbl[1] = '{1, 192, 0, 1,  0, 0};  // bit0 stuck low
    tbl[2] = '{2, 255, 0, 1,  0, 0};  // output tied low
    tbl[3] = '{3,  64, 0, 0,  8, 0};  // bit3 stuck high
    tbl[4] = '{4, 240, 0, 1,  0, 0};  // AND instead of OR
    tbl[5] = '{5, 255, 0, 0, 15, 0};  // inverted, 256 mismatches saturate

    rst = 1'b1; mode = 3'd0; bus_a.start = 1'b0; bus_b.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  32'(bus_a.busy), 0);
    chk("rst_done",  32'(bus_a.done), 0);
    chk("rst_pass",  32'(bus_a.pass), 0);
    chk("rst_err",   32'(bus_a.err_count), 0);
    chk("rst_dut_a", 32'(bus_a.dut_a), 0);
    chk("rst_fail",  32'(bus_a.fail_out), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      mode = 3'(tbl[i].mode);
      pulse_start();
      wait_done(-1, n);
      check_result($sformatf("tbl%0d", i), n, tbl[i]);
    end

    // Start mid-sweep is ignored.
    mode = 3'd1;
    pulse_start();
    wait_done(500, n);
    check_result("midstart", n, tbl[1]);

    // Start after done: fresh sweep, error count cleared on entry.
    mode = 3'd0;
    pulse_start();
    wait_done(-1, n);
    check_result("restart", n, tbl[0]);

    // Start coincident with the final CHECK is not queued.
    pulse_start();
    wait_done(1023, n);
    check_result("coinc", n, tbl[0]);
    repeat (5) @(posedge clk);
    #1;
    chk("coinc_hold_done", 32'(bus_a.done), 1);
    chk("coinc_hold_busy", 32'(bus_a.busy), 0);
    chk("coinc_dut_a",     32'(bus_a.dut_a), 15);
    chk("coinc_dut_b",     32'(bus_a.dut_b), 15);

    // Async reset mid-sweep at idx 0x37.
    mode = 3'd1;
    pulse_start();
    repeat (222) @(posedge clk);
    #1;
    chk("mid_dut_a", 32'(bus_a.dut_a), 3);
    chk("mid_dut_b", 32'(bus_a.dut_b), 7);
    chk("mid_err",   32'(bus_a.err_count), 39);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy",  32'(bus_a.busy), 0);
    chk("arst_err",   32'(bus_a.err_count), 0);
    chk("arst_dut_a", 32'(bus_a.dut_a), 0);
    chk("arst_dut_b", 32'(bus_a.dut_b), 0);
    chk("arst_fb",    32'(bus_a.fail_b), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy", 32'(bus_a.busy), 0);
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    chk("rerun_dut_a", 32'(bus_a.dut_a), 0);
    chk("rerun_dut_b", 32'(bus_a.dut_b), 1);
    wait_done(-1, n);
    chk("rerun_err", 32'(bus_a.err_count), 192);

    // WIDTH=2, SETTLE=0 instance.
    @(posedge clk); #1 bus_b.start = 1'b1;
    @(posedge clk); #1 bus_b.start = 1'b0;
    n = 0;
    while (!bus_b.done && n < 200) begin
      @(posedge clk); n++;
      #1;
    end
    chk("small_cycles", 32'(n), 33);
    chk("small_pass",   32'(bus_b.pass), 1);
    chk("small_err",    32'(bus_b.err_count), 0);
    chk("small_busy",   32'(bus_b.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
